// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Request, command, response and status bundle between the cache
//            controllers, the memory arbiter and the proc2mem/mem2proc bus.
// Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int TAG_W = 4
);
    // Dcache MSHR request port
    logic              d_req_valid;
    logic [1:0]        d_req_cmd;
    logic [31:0]       d_req_addr;
    logic [63:0]       d_req_data;
    logic              d_req_grant;
    logic [TAG_W-1:0]  d_req_tag;
    // Icache fetch request port (always a load)
    logic              i_req_valid;
    logic [31:0]       i_req_addr;
    logic              i_req_grant;
    logic [TAG_W-1:0]  i_req_tag;
    // Command to memory
    logic [1:0]        proc2mem_command;
    logic [31:0]       proc2mem_addr;
    logic [63:0]       proc2mem_data;
    // Memory replies
    logic [TAG_W-1:0]  mem2proc_transaction_tag;
    logic [TAG_W-1:0]  mem2proc_data_tag;
    logic [63:0]       mem2proc_data;
    // Routed responses and status
    logic              d_resp_valid;
    logic              i_resp_valid;
    logic [TAG_W-1:0]  resp_tag;
    logic [63:0]       resp_data;
    logic [TAG_W:0]    outstanding;

    // Arbiter side
    modport slave (
        input  d_req_valid, d_req_cmd, d_req_addr, d_req_data,
        input  i_req_valid, i_req_addr,
        input  mem2proc_transaction_tag, mem2proc_data_tag, mem2proc_data,
        output d_req_grant, d_req_tag, i_req_grant, i_req_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output d_resp_valid, i_resp_valid, resp_tag, resp_data, outstanding
    );

    // Requester / memory side
    modport master (
        output d_req_valid, d_req_cmd, d_req_addr, d_req_data,
        output i_req_valid, i_req_addr,
        output mem2proc_transaction_tag, mem2proc_data_tag, mem2proc_data,
        input  d_req_grant, d_req_tag, i_req_grant, i_req_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  d_resp_valid, i_resp_valid, resp_tag, resp_data, outstanding
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares the processor-memory port between Dcache (D) and Icache
//            (I). D has priority, I is forced through after STARVE_MAX waiting
//            cycles, a rejected requester keeps the port until accepted, and
//            returning load data is routed to the owner of its tag.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int TAG_W      = 4,
    parameter int STARVE_MAX = 4
) (
    input  wire logic      clock,
    input  wire logic      reset,     // synchronous, active-low
    mem_arbiter_if.slave   bus
);
    localparam int              c_NTAG       = 1 << TAG_W;
    localparam int              c_SW         = $clog2(STARVE_MAX + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    localparam logic [1:0] c_MEM_NONE  = 2'd0;
    localparam logic [1:0] c_MEM_LOAD  = 2'd1;
    localparam logic [1:0] c_MEM_STORE = 2'd2;

    localparam logic [1:0] c_ST_ARB    = 2'd0;
    localparam logic [1:0] c_ST_LOCK_D = 2'd1;
    localparam logic [1:0] c_ST_LOCK_I = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [c_SW-1:0]   r_starve;
    logic [c_NTAG-1:0] r_valid;
    logic [c_NTAG-1:0] r_owner;       // 0 = D, 1 = I
    logic [TAG_W:0]    r_outstanding;

    logic              w_d_req;
    logic              w_i_req;
    logic              w_arb_i;
    logic              w_sel_d;
    logic              w_sel_i;
    logic              w_issue;
    logic              w_accept;
    logic              w_set;
    logic              w_hit;
    logic              w_inc;
    logic              w_dec;
    logic [TAG_W-1:0]  w_ttag;
    logic [TAG_W-1:0]  w_dtag;

    assign w_ttag = bus.mem2proc_transaction_tag;
    assign w_dtag = bus.mem2proc_data_tag;

    // Requester selection: lock holder first, then I if starving or alone, then D
    always_comb begin
        w_d_req = bus.d_req_valid && (bus.d_req_cmd != c_MEM_NONE);
        w_i_req = bus.i_req_valid;
        w_arb_i = w_i_req && (!w_d_req || (r_starve == c_STARVE_MAX));
        w_sel_d = 1'b0;
        w_sel_i = 1'b0;
        if (reset) begin
            if ((r_state == c_ST_LOCK_D) && w_d_req) begin
                w_sel_d = 1'b1;
            end else if ((r_state == c_ST_LOCK_I) && w_i_req) begin
                w_sel_i = 1'b1;
            end else if (w_arb_i) begin
                w_sel_i = 1'b1;
            end else if (w_d_req) begin
                w_sel_d = 1'b1;
            end
        end
    end

    // Command issue, same-cycle grant, response routing and next-state decode
    always_comb begin
        w_issue  = w_sel_d || w_sel_i;
        w_accept = w_issue && (w_ttag != '0);

        bus.proc2mem_command = c_MEM_NONE;
        bus.proc2mem_addr    = 32'd0;
        bus.proc2mem_data    = 64'd0;
        if (w_sel_d) begin
            bus.proc2mem_command = bus.d_req_cmd;
            bus.proc2mem_addr    = bus.d_req_addr;
            if (bus.d_req_cmd == c_MEM_STORE) begin
                bus.proc2mem_data = bus.d_req_data;
            end
        end else if (w_sel_i) begin
            bus.proc2mem_command = c_MEM_LOAD;
            bus.proc2mem_addr    = bus.i_req_addr;
        end

        bus.d_req_grant = w_accept && w_sel_d;
        bus.i_req_grant = w_accept && w_sel_i;
        bus.d_req_tag   = (w_accept && w_sel_d) ? w_ttag : '0;
        bus.i_req_tag   = (w_accept && w_sel_i) ? w_ttag : '0;

        // Only accepted loads create an owner entry; stores never return data
        w_set = w_accept && (w_sel_i || (bus.d_req_cmd == c_MEM_LOAD));

        w_hit            = reset && (w_dtag != '0) && r_valid[w_dtag];
        bus.d_resp_valid = w_hit && !r_owner[w_dtag];
        bus.i_resp_valid = w_hit &&  r_owner[w_dtag];
        bus.resp_tag     = w_hit ? w_dtag : '0;
        bus.resp_data    = bus.mem2proc_data;

        // Overwriting a live tag adds nothing; a clear re-set in the same cycle nets to zero
        w_inc = w_set && !r_valid[w_ttag];
        w_dec = w_hit && !(w_set && (w_ttag == w_dtag));

        if (w_accept || !w_issue) begin
            w_next_state = c_ST_ARB;
        end else if (w_sel_d) begin
            w_next_state = c_ST_LOCK_D;
        end else begin
            w_next_state = c_ST_LOCK_I;
        end
    end

    assign bus.outstanding = r_outstanding;

    // State, starvation counter, owner table and outstanding-count update
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= c_ST_ARB;
            r_starve      <= '0;
            r_valid       <= '0;
            r_owner       <= '0;
            r_outstanding <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_i_req && !bus.i_req_grant) begin
                if (r_starve != c_STARVE_MAX) begin
                    r_starve <= r_starve + c_SW'(1);
                end
            end else begin
                r_starve <= '0;
            end

            // Clear first so a same-tag new acceptance overrides it
            if (w_hit) begin
                r_valid[w_dtag] <= 1'b0;
            end
            if (w_set) begin
                r_valid[w_ttag] <= 1'b1;
                r_owner[w_ttag] <= w_sel_i;
            end

            if (w_inc && !w_dec) begin
                r_outstanding <= r_outstanding + (TAG_W+1)'(1);
            end else if (w_dec && !w_inc) begin
                r_outstanding <= r_outstanding - (TAG_W+1)'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter: directed scenarios followed by
//            randomized requesters/memory, checked against a transaction-level
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int         c_STARVE    = 4;
    localparam logic [1:0] c_MEM_NONE  = 2'd0;
    localparam logic [1:0] c_MEM_LOAD  = 2'd1;
    localparam logic [1:0] c_MEM_STORE = 2'd2;

    logic clock;
    logic reset;

    mem_arbiter_if #(.TAG_W(4)) bus ();

    mem_arbiter #(.TAG_W(4), .STARVE_MAX(c_STARVE)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        dg;
        logic [3:0]  dtg;
        logic        ig;
        logic [3:0]  itg;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic        drv;
        logic        irv;
        logic [3:0]  rtg;
        logic [63:0] rdata;
        logic [4:0]  outs;
        bit          chk_outs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: who holds the port, how long I has waited, tag -> owner map
    int   m_lock = 0;          // 0 none, 1 D, 2 I
    int   m_wait = 0;
    bit   m_owner[int];        // 0 = D, 1 = I

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, push the model's expectation, advance the model
    task automatic do_cycle(input logic rst_n,
                            input logic dv, input logic [1:0] dc, input logic [31:0] da,
                            input logic [63:0] dd, input logic iv, input logic [31:0] ia,
                            input logic [3:0] tt, input logic [3:0] dt, input logic [63:0] md,
                            output logic gd, output logic gi);
        exp_t e;
        int   sel;
        bit   dv_eff, acc, hit;
        reset                        = rst_n;
        bus.d_req_valid              = dv;
        bus.d_req_cmd                = dc;
        bus.d_req_addr               = da;
        bus.d_req_data               = dd;
        bus.i_req_valid              = iv;
        bus.i_req_addr               = ia;
        bus.mem2proc_transaction_tag = tt;
        bus.mem2proc_data_tag        = dt;
        bus.mem2proc_data            = md;

        e = '{dg:0, dtg:0, ig:0, itg:0, cmd:c_MEM_NONE, addr:0, data:0,
              drv:0, irv:0, rtg:0, rdata:md, outs:0, chk_outs:0};
        if (!rst_n) begin
            q.push_back(e);
            m_lock = 0;
            m_wait = 0;
            m_owner.delete();
            gd = 1'b0;
            gi = 1'b0;
        end else begin
            dv_eff = dv && (dc != c_MEM_NONE);
            sel = 0;
            if (m_lock == 1 && dv_eff)                       sel = 1;
            else if (m_lock == 2 && iv)                      sel = 2;
            else if (iv && (!dv_eff || m_wait == c_STARVE))  sel = 2;
            else if (dv_eff)                                 sel = 1;
            acc = (sel != 0) && (tt != 4'd0);
            if (sel == 1) begin
                e.cmd  = dc;
                e.addr = da;
                e.data = (dc == c_MEM_STORE) ? dd : 64'd0;
            end else if (sel == 2) begin
                e.cmd  = c_MEM_LOAD;
                e.addr = ia;
            end
            e.dg  = acc && (sel == 1);
            e.ig  = acc && (sel == 2);
            e.dtg = e.dg ? tt : 4'd0;
            e.itg = e.ig ? tt : 4'd0;
            hit   = (dt != 4'd0) && m_owner.exists(int'(dt));
            e.drv = hit && (m_owner[int'(dt)] == 1'b0);
            e.irv = hit && (m_owner[int'(dt)] == 1'b1);
            e.rtg = hit ? dt : 4'd0;
            e.outs     = 5'(m_owner.num());
            e.chk_outs = 1'b1;
            q.push_back(e);

            m_lock = acc ? 0 : sel;
            if (iv && !e.ig) m_wait = (m_wait < c_STARVE) ? m_wait + 1 : c_STARVE;
            else             m_wait = 0;
            if (hit) m_owner.delete(int'(dt));
            if (acc && (sel == 2 || dc == c_MEM_LOAD)) m_owner[int'(tt)] = (sel == 2);
            gd = e.dg;
            gi = e.ig;
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: every cycle the DUT presents outputs, pop and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("d_req_grant",  64'(bus.d_req_grant),      64'(e.dg));
                chk("d_req_tag",    64'(bus.d_req_tag),        64'(e.dtg));
                chk("i_req_grant",  64'(bus.i_req_grant),      64'(e.ig));
                chk("i_req_tag",    64'(bus.i_req_tag),        64'(e.itg));
                chk("command",      64'(bus.proc2mem_command), 64'(e.cmd));
                chk("addr",         64'(bus.proc2mem_addr),    64'(e.addr));
                chk("data",         bus.proc2mem_data,         e.data);
                chk("d_resp_valid", 64'(bus.d_resp_valid),     64'(e.drv));
                chk("i_resp_valid", 64'(bus.i_resp_valid),     64'(e.irv));
                chk("resp_tag",     64'(bus.resp_tag),         64'(e.rtg));
                if (e.drv || e.irv) chk("resp_data", bus.resp_data, e.rdata);
                if (e.chk_outs)     chk("outstanding", 64'(bus.outstanding), 64'(e.outs));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic        gd, gi;
        bit          d_pend, i_pend;
        logic [1:0]  d_cmd;
        logic [31:0] d_addr, i_addr;
        logic [63:0] d_data;
        logic [3:0]  tt, dt;
        logic        rn;

        reset = 1'b0;
        bus.d_req_valid = 0; bus.d_req_cmd = 0; bus.d_req_addr = 0; bus.d_req_data = 0;
        bus.i_req_valid = 0; bus.i_req_addr = 0;
        bus.mem2proc_transaction_tag = 0; bus.mem2proc_data_tag = 0; bus.mem2proc_data = 0;
        @(posedge clock);
        #1;

        // Reset
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gd, gi);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gd, gi);
        // D load, tag 3, then data returns on tag 3
        do_cycle(1, 1, c_MEM_LOAD, 32'h100, 0, 0, 0, 4'd3, 0, 0, gd, gi);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, gd, gi);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 4'd3, 64'h1111_2222_3333_4444, gd, gi);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, gd, gi);
        // D and I both valid: D wins four times, I forced on the fifth
        for (int k = 1; k <= 5; k++)
            do_cycle(1, 1, c_MEM_LOAD, 32'h400 + k, 0, 1, 32'h800, 4'(k), 0, 0, gd, gi);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, gd, gi);
        // I rejected twice, D arrives, locked I wins with tag 7
        do_cycle(1, 0, 0, 0, 0, 1, 32'h900, 4'd0, 0, 0, gd, gi);
        do_cycle(1, 0, 0, 0, 0, 1, 32'h900, 4'd0, 0, 0, gd, gi);
        do_cycle(1, 1, c_MEM_LOAD, 32'hA00, 0, 1, 32'h900, 4'd7, 0, 0, gd, gi);
        do_cycle(1, 1, c_MEM_LOAD, 32'hA00, 0, 0, 0, 4'd8, 0, 0, gd, gi);
        // D store, tag 6: no table entry, stray data tag 6 dropped
        do_cycle(1, 1, c_MEM_STORE, 32'h200, 64'hDEADBEEF, 0, 0, 4'd6, 0, 0, gd, gi);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 4'd6, 64'h55, gd, gi);
        // Tag 9 returns to I while D is accepted on tag 9; later tag 9 goes to D
        do_cycle(1, 0, 0, 0, 0, 1, 32'hB00, 4'd9, 0, 0, gd, gi);
        do_cycle(1, 1, c_MEM_LOAD, 32'hC00, 0, 0, 0, 4'd9, 4'd9, 64'h99, gd, gi);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 4'd9, 64'h98, gd, gi);
        // Three loads outstanding, reset drops ownership
        for (int k = 10; k <= 12; k++)
            do_cycle(1, 1, c_MEM_LOAD, 32'hD00 + k, 0, 0, 0, 4'(k), 0, 0, gd, gi);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gd, gi);
        for (int k = 10; k <= 12; k++)
            do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 4'(k), 64'(k), gd, gi);

        // Randomized traffic
        d_pend = 0; i_pend = 0;
        d_cmd = 0; d_addr = 0; d_data = 0; i_addr = 0;
        for (int n = 0; n < 2500; n++) begin
            if (!d_pend && ($urandom % 3 == 0)) begin
                d_pend = 1;
                case ($urandom % 8)
                    0:       d_cmd = c_MEM_NONE;
                    1, 2, 3: d_cmd = c_MEM_STORE;
                    default: d_cmd = c_MEM_LOAD;
                endcase
                d_addr = $urandom;
                d_data = {$urandom, $urandom};
            end
            if (!i_pend && ($urandom % 3 == 0)) begin
                i_pend = 1;
                i_addr = $urandom;
            end
            if (d_pend && ($urandom % 12 == 0)) d_pend = 0;
            if (i_pend && ($urandom % 12 == 0)) i_pend = 0;
            tt = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            dt = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rn = ($urandom % 150 == 0) ? 1'b0 : 1'b1;
            do_cycle(rn, d_pend, d_cmd, d_addr, d_data, i_pend, i_addr, tt, dt,
                     {$urandom, $urandom}, gd, gi);
            if (gd) d_pend = 0;
            if (gi) i_pend = 0;
        end
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, gd, gi);

        repeat (3) @(negedge clock);
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
